// File: rtl/operand_skid_buffer_pkg.sv
// rtl/operand_skid_buffer_pkg.sv - shared operand/adder definitions: state encoding and default width
package operand_skid_buffer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/operand_skid_buffer_pair_reg.sv
// rtl/operand_skid_buffer_pair_reg.sv - operand pair register with load enable and async clear
module pair_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_skid_buffer.sv
// rtl/operand_skid_buffer.sv - two-entry skid buffer registering operand pairs into the adder stage
module operand_skid_buffer
  import operand_skid_buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [1:0]       level
);

  localparam int PAIR_W = 2 * WIDTH;

  skid_state_e       state, next_state;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, main_from_skid;
  logic [PAIR_W-1:0] main_d, main_q, skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    next_state     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          next_state = BUSY;
          load_main  = 1'b1;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (!in_fire && out_fire) begin
          next_state = EMPTY;
        end else if (in_fire && out_fire) begin
          load_main = 1'b1;
        end
      end
      FULL: begin
        if (out_fire) begin
          next_state     = BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : {in_a, in_b};

  // in_ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      level     <= 2'd0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state != EMPTY);
      in_ready  <= (next_state != FULL);
      level     <= next_state;
    end
  end

  pair_reg #(.WIDTH(PAIR_W)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  pair_reg #(.WIDTH(PAIR_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (load_skid),
    .d     ({in_a, in_b}),
    .q     (skid_q)
  );

  assign {out_a, out_b} = main_q;

endmodule

// File: tb/tb_operand_skid_buffer.sv
// tb/tb_operand_skid_buffer.sv - scoreboard bench for operand_skid_buffer
module tb_operand_skid_buffer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [1:0]  level;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_in     = 0;
  int          n_out    = 0;
  bit          mon_en   = 0;
  logic [63:0] exp_q[$];

  operand_skid_buffer #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus: inputs set just after a rising edge; acceptance is
  // decided from in_ready seen mid-cycle and logged into the model just after.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic r);
    logic acc;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    @(negedge clock);
    acc = v && in_ready;
    #1;
    if (acc) begin
      exp_q.push_back({a, b});
      n_in++;
    end
    @(posedge clock);
    #1;
  endtask

  // Model: level is the number of accepted-but-unconsumed pairs; the head of
  // the queue must be on the output whenever one is held.
  always @(negedge clock) begin
    if (mon_en) begin
      check("level", {62'd0, level}, 64'(exp_q.size()));
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
      if (out_valid && exp_q.size() != 0) begin
        check("out_pair", {out_a, out_b}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    int guard;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    reset = 0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_level", {62'd0, level}, 64'd0);
    check("rst_out_pair", {out_a, out_b}, 64'd0);
    @(posedge clock); #1;
    reset = 1;
    check("rel_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clock); #1;
    check("rel_in_ready_high", {63'd0, in_ready}, 64'd1);
    mon_en = 1;

    // single pass
    step(1, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    check("single_valid", {63'd0, out_valid}, 64'd1);
    check("single_pair", {out_a, out_b}, 64'hFFFF_FFFF_0000_0001);
    step(0, 0, 0, 1);
    check("single_empty", {62'd0, level}, 64'd0);

    // backpressure and drain
    step(1, 1, 2, 0);
    step(1, 3, 4, 0);
    check("bp_level", {62'd0, level}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_pair", {out_a, out_b}, {32'd1, 32'd2});
    step(1, 5, 6, 0);
    check("bp_held_level", {62'd0, level}, 64'd2);
    check("bp_held_pair", {out_a, out_b}, {32'd1, 32'd2});
    step(0, 0, 0, 1);
    check("drain1_level", {62'd0, level}, 64'd1);
    check("drain1_pair", {out_a, out_b}, {32'd3, 32'd4});
    step(0, 0, 0, 1);
    check("drain2_level", {62'd0, level}, 64'd0);
    step(1, 5, 6, 1);
    check("late_pair", {out_a, out_b}, {32'd5, 32'd6});

    // streaming
    for (int i = 0; i < 100; i++) begin
      step(1, 32'(i), 32'(i + 1), 1);
      check("stream_level", {62'd0, level}, 64'd1);
    end
    step(0, 0, 0, 1);
    check("stream_drained", {62'd0, level}, 64'd0);

    // random
    n_in = 0; n_out = 0;
    guard = 0;
    while (n_in < 10000 && guard < 60000) begin
      step($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) < 7);
      guard++;
    end
    check("rand_all_sent", 64'(n_in), 64'd10000);
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      step(0, 0, 0, 1);
      guard++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_no_loss", 64'(n_out), 64'(n_in));

    // reset mid-stream while full
    step(1, 32'hA, 32'hB, 0);
    step(1, 32'hC, 32'hD, 0);
    check("pre_rst_level", {62'd0, level}, 64'd2);
    mon_en = 0;
    in_valid = 0;
    reset = 0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("mid_rst_level", {62'd0, level}, 64'd0);
    check("mid_rst_pair", {out_a, out_b}, 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1;
    check("mid_rel_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(posedge clock); #1;
    check("mid_rel_in_ready_high", {63'd0, in_ready}, 64'd1);
    check("mid_rel_out_valid", {63'd0, out_valid}, 64'd0);
    mon_en = 1;
    step(1, 32'h1234, 32'h5678, 1);
    check("post_rst_pair", {out_a, out_b}, {32'h1234, 32'h5678});
    step(0, 0, 0, 1);
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/operand_skid_buffer.md
OPERAND_SKID_BUFFER -- requirements
Module: operand_skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port in_valid  input  1  upstream operand pair present.
REQ-005 SHALL have port in_ready  output  1  buffer accepts a pair this cycle.
REQ-006 SHALL have port in_a  input  WIDTH  operand A.
REQ-007 SHALL have port in_b  input  WIDTH  operand B.
REQ-008 SHALL have port out_valid  output  1  registered pair available to the adder stage.
REQ-009 SHALL have port out_ready  input  1  adder stage consumes the pair this cycle.
REQ-010 SHALL have port out_a  output  WIDTH  registered operand A.
REQ-011 SHALL have port out_b  output  WIDTH  registered operand B.
REQ-012 SHALL have port level  output  2  occupancy: 0, 1 or 2 pairs held.

Function
REQ-013 SHALL transfer on the input side iff in_valid & in_ready at a rising edge (in_fire); on the output side iff out_valid & out_ready (out_fire).
REQ-014 SHALL drive in_ready, out_valid, out_a, out_b and level from flops only; no combinational path from any input to any output.
REQ-015 SHALL hold a main register (drives out_a/out_b) and a skid register, with states EMPTY (level 0), BUSY (level 1), FULL (level 2).
REQ-016 EMPTY: in_fire -> BUSY, main <= {in_a,in_b}; else stay.
REQ-017 BUSY: in_fire & !out_fire -> FULL, skid <= input; !in_fire & out_fire -> EMPTY; in_fire & out_fire -> BUSY, main <= input; neither -> stay.
REQ-018 FULL: out_fire -> BUSY, main <= skid; else stay; no input accepted while FULL.
REQ-019 SHALL set out_valid = (state != EMPTY) and in_ready = (state != FULL), both registered alongside state.
REQ-020 SHALL have latency exactly 1 cycle from in_fire in EMPTY to out_valid high with that pair on out_a/out_b.
REQ-021 SHALL preserve order: pairs leave in acceptance order; none dropped or duplicated.
REQ-022 SHALL hold out_a/out_b stable while out_valid & !out_ready.
REQ-023 SHALL sustain one pair per cycle when in_valid and out_ready stay high (steady state BUSY).
REQ-024 SHALL ignore in_a/in_b when in_fire is false; skid contents are don't-care outside FULL.

Reset
REQ-025 SHALL, while reset is low, force state EMPTY, out_valid 0, in_ready 0, level 0, out_a 0, out_b 0, skid 0, regardless of clock.
REQ-026 SHALL raise in_ready at the first rising edge after reset deasserts; no pair accepted before that edge.
REQ-027 SHALL abandon any held pairs when reset asserts mid-operation; no partial output afterwards.

Structure
REQ-028 SHALL take the state encoding (EMPTY=0, BUSY=1, FULL=2) and default WIDTH from the shared adder package, used by this block and the adder stage.
REQ-029 SHALL instantiate one sub-module, pair_reg: 2*WIDTH register with load enable and async active-low clear, used for both main and skid.
REQ-030 SHALL connect out_a/out_b/out_valid directly to the adder stage inputs, giving registered operands into the adder.

Verification
REQ-031 Reset: assert reset low mid-stream with level 2 -> out_valid 0, in_ready 0, level 0, out_a/out_b 0 immediately; in_ready 1 one edge after release.
REQ-032 Single pass: EMPTY, in_a=0xFFFFFFFF, in_b=0x00000001, out_ready 1 -> next cycle out_valid 1, out_a 0xFFFFFFFF, out_b 0x00000001; EMPTY the cycle after.
REQ-033 Backpressure: out_ready 0, send pairs (1,2),(3,4) -> level 2, in_ready 0, out shows (1,2); third pair (5,6) held off until out_ready.
REQ-034 Drain: from REQ-033 state set out_ready 1 -> (1,2) then (3,4) on consecutive cycles, level 2->1->0.
REQ-035 Streaming: in_valid and out_ready high 100 cycles with pairs (i,i+1) -> 100 outputs in order, one per cycle, level stays 1.
REQ-036 Random: random in_valid/out_ready, 10k pairs -> scoreboard shows order preserved, no loss, outputs stable under stall.
